// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one external memory interface between two interface routers:
//   m0 = instruction-side router, m1 = data-side router.
// One router is granted at a time, and the grant is held for a whole
// transaction. An INCR or WRAP transaction lasts BURST_LENGTH beats. A single
// or reserved transaction lasts one beat. A beat is a cycle with
// ACK & ~STALL & REQ, where REQ is the granted router's request. After every
// completed or aborted transaction the arbiter spends one cycle in IDLE
// before it grants again.
//
// Optional feature (compile-time macro):
//   ARB_ROUND_ROBIN_EN  defined   : when both routers request in IDLE, the
//                                   router that was not granted last wins.
//                                   After reset, m1 wins the first conflict.
//                       undefined : fixed priority; m1 always wins a conflict.
//
// Parameters
//   BURST_LENGTH  beats per INCR/WRAP transaction (power of 2, 2..16)
//   CNT_W         beat counter width, >= $clog2(BURST_LENGTH)+1
//
// Ports
//   clk, reset                         clock; synchronous active-high reset
//   mX_addr_i/burst_i/req_i/wrb_i/
//   mX_wdata_i/bstrb_i                 router X request side (X = 0, 1)
//   mX_rdata_o/ack_o/stall_o           router X response side
//   ADDR_o/BURST_o/REQ_o/WRB_o/
//   WDATA_o/BSTROBE_o                  towards memory; all zero while idle
//   RDATA_i/ACK_i/STALL_i              from memory
//   gnt_o                              one-hot grant: bit0 = m0, bit1 = m1
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int BURST_LENGTH = 8,
  parameter int CNT_W        = 5
) (
  input  logic        clk,
  input  logic        reset,

  // instruction-side router
  input  logic [31:0] m0_addr_i,
  input  logic [1:0]  m0_burst_i,
  input  logic        m0_req_i,
  input  logic        m0_wrb_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_bstrb_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_ack_o,
  output logic        m0_stall_o,

  // data-side router
  input  logic [31:0] m1_addr_i,
  input  logic [1:0]  m1_burst_i,
  input  logic        m1_req_i,
  input  logic        m1_wrb_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_bstrb_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_ack_o,
  output logic        m1_stall_o,

  // memory side
  output logic [31:0] ADDR_o,
  output logic [1:0]  BURST_o,
  output logic        REQ_o,
  output logic        WRB_o,
  output logic [31:0] WDATA_o,
  output logic [3:0]  BSTROBE_o,
  input  logic [31:0] RDATA_i,
  input  logic        ACK_i,
  input  logic        STALL_i,

  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] len_q, len_d;

  logic sel_req;    // request of the router that currently holds the grant
  logic beat;
  logic last_beat;
  logic abort;
  logic prefer_m1;  // conflict tie-break in IDLE
  logic pick_m1;

  // Transaction length taken from the burst code. The reserved code 11
  // behaves like a single transfer.
  function automatic logic [CNT_W-1:0] burst_len(input logic [1:0] burst);
    if (burst == BURST_INCR || burst == BURST_WRAP) begin
      return CNT_W'(BURST_LENGTH);
    end
    return CNT_W'(1);
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  // 0 = m0 completed the most recent transaction, 1 = m1 did. An aborted
  // transaction leaves this unchanged, so aborting does not cost a router
  // its turn.
  logic last_gnt_q, last_gnt_d;

  assign prefer_m1 = ~last_gnt_q;
`else
  assign prefer_m1 = 1'b1;
`endif

  assign pick_m1 = m1_req_i & (~m0_req_i | prefer_m1);

  assign sel_req   = (state_q == GNT1) ? m1_req_i : m0_req_i;
  assign beat      = (state_q != IDLE) & ACK_i & ~STALL_i & sel_req;
  assign last_beat = beat & (beat_cnt_q == len_q - CNT_W'(1));
  // The router gives up before any data has moved. Once at least one beat
  // has completed, a dropped request is only a gap inside the burst and the
  // grant is kept.
  assign abort     = (state_q != IDLE) & ~sel_req & (beat_cnt_q == '0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      len_q      <= CNT_W'(1);
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt_q <= last_gnt_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: arbitration, beat counting, release
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first. A path that leaves
  // a signal unassigned would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_gnt_d = last_gnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        if (pick_m1) begin
          state_d = GNT1;
          len_d   = burst_len(m1_burst_i);
        end else if (m0_req_i) begin
          state_d = GNT0;
          len_d   = burst_len(m0_burst_i);
        end
      end

      GNT0, GNT1: begin
        if (last_beat) begin
          // The counter stops at len-1 and clears here, so it never wraps.
          state_d    = IDLE;
          beat_cnt_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_gnt_d = (state_q == GNT1);
`endif
        end else if (abort) begin
          state_d = IDLE;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: memory-side mux and per-router handshake
  // ---------------------------------------------------------------------------
  // Read data goes to both routers unconditionally. A router only uses it
  // together with its own ack, which is forced low while it is not granted.
  assign m0_rdata_o = RDATA_i;
  assign m1_rdata_o = RDATA_i;

  always_comb begin
    ADDR_o     = '0;
    BURST_o    = '0;
    REQ_o      = 1'b0;
    WRB_o      = 1'b0;
    WDATA_o    = '0;
    BSTROBE_o  = '0;
    gnt_o      = 2'b00;
    m0_ack_o   = 1'b0;
    m0_stall_o = 1'b1;
    m1_ack_o   = 1'b0;
    m1_stall_o = 1'b1;

    unique case (state_q)
      GNT0: begin
        ADDR_o     = m0_addr_i;
        BURST_o    = m0_burst_i;
        REQ_o      = m0_req_i;
        WRB_o      = m0_wrb_i;
        WDATA_o    = m0_wdata_i;
        BSTROBE_o  = m0_bstrb_i;
        m0_ack_o   = ACK_i;
        m0_stall_o = STALL_i;
        gnt_o      = 2'b01;
      end

      GNT1: begin
        ADDR_o     = m1_addr_i;
        BURST_o    = m1_burst_i;
        REQ_o      = m1_req_i;
        WRB_o      = m1_wrb_i;
        WDATA_o    = m1_wdata_i;
        BSTROBE_o  = m1_bstrb_i;
        m1_ack_o   = ACK_i;
        m1_stall_o = STALL_i;
        gnt_o      = 2'b10;
      end

      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Self-checking bench for mem_bus_arbiter.
//   - Router tasks issue transactions. Each issued transaction pushes its
//     expected memory-side beats into a per-router scoreboard queue.
//   - A monitor pops that queue on every memory-side beat and compares the
//     data. It also compares the grant and the handshake, every cycle,
//     against a transaction-level model of the arbitration rules.
//   - A memory responder runs in one of three modes: random, ack every
//     cycle with scripted stalls, or quiet.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int BL = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // Router-driven inputs, indexed by router id.
  logic [1:0][31:0] r_addr, r_wdata;
  logic [1:0][1:0]  r_burst;
  logic [1:0][3:0]  r_bstrb;
  logic [1:0]       r_req, r_wrb;

  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        m0_ack_o, m0_stall_o, m1_ack_o, m1_stall_o;
  logic [31:0] ADDR_o, WDATA_o, RDATA_i;
  logic [1:0]  BURST_o, gnt_o;
  logic        REQ_o, WRB_o, ACK_i, STALL_i;
  logic [3:0]  BSTROBE_o;
  logic [1:0]  ack_v, stall_v;

  assign ack_v   = {m1_ack_o, m0_ack_o};
  assign stall_v = {m1_stall_o, m0_stall_o};

  mem_bus_arbiter #(.BURST_LENGTH(BL), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .m0_addr_i(r_addr[0]), .m0_burst_i(r_burst[0]), .m0_req_i(r_req[0]),
    .m0_wrb_i(r_wrb[0]), .m0_wdata_i(r_wdata[0]), .m0_bstrb_i(r_bstrb[0]),
    .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o), .m0_stall_o(m0_stall_o),
    .m1_addr_i(r_addr[1]), .m1_burst_i(r_burst[1]), .m1_req_i(r_req[1]),
    .m1_wrb_i(r_wrb[1]), .m1_wdata_i(r_wdata[1]), .m1_bstrb_i(r_bstrb[1]),
    .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o), .m1_stall_o(m1_stall_o),
    .ADDR_o(ADDR_o), .BURST_o(BURST_o), .REQ_o(REQ_o), .WRB_o(WRB_o),
    .WDATA_o(WDATA_o), .BSTROBE_o(BSTROBE_o),
    .RDATA_i(RDATA_i), .ACK_i(ACK_i), .STALL_i(STALL_i),
    .gnt_o(gnt_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wrb;
    logic [3:0]  bstrb;
    int          beats;
  } exp_t;

  exp_t        sb0[$], sb1[$];
  int          sb_seen0 = 0, sb_seen1 = 0;
  int          done_order[$];
  logic [31:0] rx0[$], rx1[$];

  function automatic int txn_len(input logic [1:0] burst);
    return (burst == 2'b01 || burst == 2'b10) ? BL : 1;
  endfunction

  // ---------------------------------------------------------------------------
  // Transaction-level model of the arbitration rules
  //   own: 0 = nobody granted, 1 = m0 granted, 2 = m1 granted
  // ---------------------------------------------------------------------------
  int own = 0, m_done = 0, m_need = 1;
  bit m_last_m1 = 1'b0;

  function automatic int pick(input logic [1:0] req, input bit last_m1);
    if (req == 2'b11) return RR_EN ? (last_m1 ? 0 : 1) : 1;
    return req[1] ? 1 : 0;
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      own = 0; m_done = 0; m_last_m1 = 1'b0;
    end else if (own == 0) begin
      if (r_req != 2'b00) begin
        own    = pick(r_req, m_last_m1) + 1;
        m_done = 0;
        m_need = txn_len(r_burst[own-1]);
      end
    end else if (!r_req[own-1]) begin
      if (m_done == 0) own = 0;
    end else if (ACK_i && !STALL_i) begin
      m_done++;
      if (m_done == m_need) begin
        m_last_m1 = (own == 2);
        own = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: per-cycle grant/handshake checks and scoreboard pops
  // ---------------------------------------------------------------------------
  task automatic sb_beat(input int id);
    exp_t e;
    bit   have;
    have = (id == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
    check("sb_pending", have, 1'b1);
    if (have) begin
      e = (id == 0) ? sb0[0] : sb1[0];
      check("sb_beat", {ADDR_o, WDATA_o, WRB_o, BSTROBE_o}, {e.addr, e.wdata, e.wrb, e.bstrb});
      if (id == 0) begin
        sb_seen0++;
        if (sb_seen0 == e.beats) begin void'(sb0.pop_front()); sb_seen0 = 0; done_order.push_back(0); end
      end else begin
        sb_seen1++;
        if (sb_seen1 == e.beats) begin void'(sb1.pop_front()); sb_seen1 = 0; done_order.push_back(1); end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (reset) begin
      sb0.delete(); sb1.delete(); sb_seen0 = 0; sb_seen1 = 0;
    end else begin
      check("gnt", gnt_o, (own == 0) ? 2'b00 : (own == 1) ? 2'b01 : 2'b10);
      if (own == 0) begin
        check("idle_mem", {ADDR_o, BURST_o, REQ_o, WRB_o, WDATA_o, BSTROBE_o}, '0);
        check("idle_router", {ack_v, stall_v}, 4'b0011);
      end else begin
        check("mem_mux", {ADDR_o, BURST_o, REQ_o, WRB_o, WDATA_o, BSTROBE_o},
              {r_addr[own-1], r_burst[own-1], r_req[own-1], r_wrb[own-1],
               r_wdata[own-1], r_bstrb[own-1]});
        check("router_hs", {ack_v[own-1], stall_v[own-1], ack_v[2-own], stall_v[2-own]},
              {ACK_i, STALL_i, 1'b0, 1'b1});
      end
      check("rdata", {m0_rdata_o, m1_rdata_o}, {RDATA_i, RDATA_i});
      if (REQ_o && ACK_i && !STALL_i) begin
        check("beat_has_grant", (gnt_o == 2'b01) || (gnt_o == 2'b10), 1'b1);
        if (gnt_o == 2'b01) sb_beat(0);
        else if (gnt_o == 2'b10) sb_beat(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory responder
  //   mode 0: random ACK/STALL/RDATA
  //   mode 1: ACK every cycle, RDATA = 0x100 + beat index,
  //           STALL for stall_len cycles on beat indices set in stall_mask
  //   mode 2: quiet (no ACK)
  // ---------------------------------------------------------------------------
  int          mem_mode = 2;
  logic [15:0] stall_mask = '0;
  int          stall_len = 0;

  initial begin
    int idx = 0, sd = 0;
    bit mb, st, idle;
    ACK_i = 1'b0; STALL_i = 1'b0; RDATA_i = '0;
    forever begin
      @(negedge clk);
      mb = REQ_o & ACK_i & ~STALL_i;
      st = REQ_o & STALL_i;
      idle = (gnt_o == 2'b00);
      @(posedge clk);
      #2;
      if (idle) begin idx = 0; sd = 0; end
      else if (mb) begin idx++; sd = 0; end
      else if (st) sd++;
      case (mem_mode)
        0: begin
          ACK_i = ($urandom_range(0, 3) != 0);
          STALL_i = ($urandom_range(0, 3) == 0);
          RDATA_i = $urandom;
        end
        1: begin
          ACK_i = 1'b1;
          STALL_i = (idx < 16) && stall_mask[idx] && (sd < stall_len);
          RDATA_i = 32'h100 + 32'(idx);
        end
        default: begin
          ACK_i = 1'b0; STALL_i = 1'b0; RDATA_i = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Router tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input int id, input logic [1:0] burst, input logic wrb);
    r_addr[id]  = $urandom;
    r_wdata[id] = $urandom;
    r_bstrb[id] = 4'($urandom);
    r_burst[id] = burst;
    r_wrb[id]   = wrb;
  endtask

  task automatic push_exp(input int id);
    exp_t e;
    e.addr = r_addr[id]; e.wdata = r_wdata[id]; e.wrb = r_wrb[id];
    e.bstrb = r_bstrb[id]; e.beats = txn_len(r_burst[id]);
    if (id == 0) sb0.push_back(e); else sb1.push_back(e);
  endtask

  task automatic finish_txn(input int id, input int n, input bit gaps);
    int got = 0, guard = 0;
    bit beat;
    while (got < n && guard < 5000) begin
      @(negedge clk);
      beat = r_req[id] & ack_v[id] & ~stall_v[id] & ~reset;
      if (beat) begin
        if (id == 0) rx0.push_back(m0_rdata_o); else rx1.push_back(m1_rdata_o);
      end
      @(posedge clk);
      #1;
      guard++;
      if (beat) got++;
      if (got < n) r_req[id] = !(gaps && got > 0 && $urandom_range(0, 3) == 0);
    end
    r_req[id] = 1'b0;
    check("txn_beats", got, n);
  endtask

  task automatic txn(input int id, input logic [1:0] burst, input logic wrb, input bit gaps);
    drive(id, burst, wrb);
    push_exp(id);
    r_req[id] = 1'b1;
    finish_txn(id, txn_len(burst), gaps);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    r_req = '0; r_addr = '0; r_wdata = '0; r_burst = '0; r_bstrb = '0; r_wrb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {gnt_o, REQ_o, ack_v, stall_v}, {2'b00, 1'b0, 2'b00, 2'b11});
    reset = 1'b0;

    // m0 INCR read alone, ack every cycle.
    mem_mode = 1; stall_mask = '0; stall_len = 0;
    rx0.delete();
    fork
      txn(0, 2'b01, 1'b0, 1'b0);
      begin @(posedge clk); #1; check("t1_gnt_after_1cyc", gnt_o, 2'b01); end
    join
    check("t1_gnt_idle_after_last", gnt_o, 2'b00);
    check("t1_rx_count", rx0.size(), BL);
    for (int i = 0; i < BL && i < rx0.size(); i++) check("t1_rdata", rx0[i], 32'h100 + 32'(i));

    // Simultaneous INCR requests, two rounds.
    done_order.delete();
    repeat (2) fork
      txn(0, 2'b01, 1'b0, 1'b0);
      txn(1, 2'b10, 1'b1, 1'b0);
    join
    check("t2_order", {done_order.size() == 4 ? 1'b1 : 1'b0}, 1'b1);
    if (done_order.size() == 4)
      check("t2_order_seq", {2'(done_order[0]), 2'(done_order[1]), 2'(done_order[2]), 2'(done_order[3])},
            {2'd1, 2'd0, 2'd1, 2'd0});

    // m1 single write, stalled for three cycles before its ack.
    stall_mask = 16'h0001; stall_len = 3;
    rx1.delete();
    txn(1, 2'b00, 1'b1, 1'b0);
    check("t3_one_beat", rx1.size(), 1);
    check("t3_idle_next", gnt_o, 2'b00);

    // m0 burst stalled on beats 3 and 5, m1 single requested meanwhile.
    stall_mask = 16'h0028; stall_len = 1;
    rx0.delete(); done_order.delete();
    fork
      txn(0, 2'b01, 1'b0, 1'b0);
      begin repeat (3) @(posedge clk); #1; txn(1, 2'b00, 1'b0, 1'b0); end
    join
    check("t4_rx_count", rx0.size(), BL);
    for (int i = 0; i < BL && i < rx0.size(); i++) check("t4_rdata", rx0[i], 32'h100 + 32'(i));
    check("t4_order", {done_order.size() == 2 ? 1'b1 : 1'b0, 1'(done_order.size() > 0 ? done_order[0] : 1)},
          {1'b1, 1'b0});

    // m1 granted, then drops its request before any beat; m0 is pending.
    mem_mode = 2; stall_mask = '0;
    drive(1, 2'b01, 1'b0);
    r_req[1] = 1'b1;
    @(posedge clk); #1;
    check("t5_m1_granted", gnt_o, 2'b10);
    r_req[1] = 1'b0;
    drive(0, 2'b00, 1'b0);
    r_req[0] = 1'b1;
    @(posedge clk); #1;
    check("t5_abort_idle", gnt_o, 2'b00);
    @(posedge clk); #1;
    check("t5_m0_granted", gnt_o, 2'b01);
    push_exp(0);
    mem_mode = 1;
    finish_txn(0, 1, 1'b0);

    // Reset during beat 4 of an m0 burst.
    txn_reset_test();

    // Randomized traffic from both routers.
    mem_mode = 0;
    done_order.delete();
    fork
      for (int n = 0; n < 25; n++) begin
        int k = $urandom_range(0, 3);
        if (k > 0) begin repeat (k) @(posedge clk); #1; end
        txn(0, 2'($urandom_range(0, 3)), 1'($urandom), 1'b1);
      end
      for (int n = 0; n < 25; n++) begin
        int k = $urandom_range(0, 3);
        if (k > 0) begin repeat (k) @(posedge clk); #1; end
        txn(1, 2'($urandom_range(0, 3)), 1'($urandom), 1'b1);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    check("rand_completed", done_order.size(), 50);
    check("sb_drained", {sb0.size() == 0 ? 1'b1 : 1'b0, sb1.size() == 0 ? 1'b1 : 1'b0}, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic txn_reset_test();
    mem_mode = 1; stall_mask = '0;
    drive(0, 2'b01, 1'b0);
    push_exp(0);
    r_req[0] = 1'b1;
    // Grant lands on the first edge; beats 0..3 complete on the next four.
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6_reset_mem", {REQ_o, ADDR_o, WDATA_o, BURST_o}, '0);
    check("t6_reset_gnt", {gnt_o, ack_v, stall_v}, {2'b00, 2'b00, 2'b11});
    r_req[0] = 1'b0;
    reset = 1'b0;
    rx0.delete();
    fork
      txn(0, 2'b01, 1'b0, 1'b0);
      begin @(posedge clk); #1; check("t6_regrant_1cyc", gnt_o, 2'b01); end
    join
    // A leftover count from the interrupted burst would end this one early.
    check("t6_full_burst", rx0.size(), BL);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
